// File: rtl/reorder_buffer.sv
// Two-wide in-order reorder buffer: dual dispatch, out-of-order finish marking,
// up to two in-order retirements per cycle with registered ARF update strobes.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            alloc_en_A,
    input  logic            alloc_en_B,
    input  logic            alloc_wr_A,
    input  logic            alloc_wr_B,
    input  logic [4:0]      alloc_rd_A,
    input  logic [4:0]      alloc_rd_B,
    output logic            alloc_ready,
    output logic [TAGW-1:0] alloc_tag_A,
    output logic [TAGW-1:0] alloc_tag_B,
    input  logic            fin_en_A,
    input  logic            fin_en_B,
    input  logic [TAGW-1:0] fin_tag_A,
    input  logic [TAGW-1:0] fin_tag_B,
    output logic            updateEnA,
    output logic            updateEnB,
    output logic [4:0]      updateAddrA,
    output logic [4:0]      updateAddrB,
    output logic [TAGW:0]   count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] wr;
    logic [4:0]       rd [DEPTH];

    logic [TAGW-1:0] head;
    logic [TAGW-1:0] tail;
    logic [TAGW-1:0] headP1;
    logic            retire0;
    logic            retire1;
    logic            doAllocA;
    logic            doAllocB;
    logic            updA;
    logic            updB;
    logic [1:0]      numAlloc;
    logic [1:0]      numRetire;

    assign headP1      = head + TAGW'(1);
    assign alloc_ready = (count <= (TAGW+1)'(DEPTH - 2));
    assign alloc_tag_A = tail;
    assign alloc_tag_B = alloc_en_A ? tail + TAGW'(1) : tail;
    assign doAllocA    = alloc_ready & alloc_en_A;
    assign doAllocB    = alloc_ready & alloc_en_B;

    // done is read from state, so a finish landing at an edge retires on the next one
    assign retire0   = valid[head] & done[head];
    assign retire1   = retire0 & valid[headP1] & done[headP1];
    assign updA      = retire0 & wr[head];
    assign updB      = retire1 & wr[headP1];
    assign numAlloc  = {1'b0, doAllocA} + {1'b0, doAllocB};
    assign numRetire = {1'b0, retire0} + {1'b0, retire1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= '0;
            done        <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            updateEnA   <= 1'b0;
            updateEnB   <= 1'b0;
            updateAddrA <= '0;
            updateAddrB <= '0;
        end else if (flush) begin
            valid       <= '0;
            done        <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            updateEnA   <= 1'b0;
            updateEnB   <= 1'b0;
            updateAddrA <= '0;
            updateAddrB <= '0;
        end else begin
            // later assignments win: retire clears, then fresh allocations set
            if (fin_en_A && valid[fin_tag_A]) done[fin_tag_A] <= 1'b1;
            if (fin_en_B && valid[fin_tag_B]) done[fin_tag_B] <= 1'b1;
            if (retire0) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (retire1) begin
                valid[headP1] <= 1'b0;
                done[headP1]  <= 1'b0;
            end
            if (doAllocA) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
            end
            if (doAllocB) begin
                valid[alloc_tag_B] <= 1'b1;
                done[alloc_tag_B]  <= 1'b0;
            end
            head        <= head + TAGW'(numRetire);
            tail        <= tail + TAGW'(numAlloc);
            count       <= count + (TAGW+1)'(numAlloc) - (TAGW+1)'(numRetire);
            updateEnA   <= updA;
            updateEnB   <= updB;
            updateAddrA <= updA ? rd[head]   : 5'd0;
            updateAddrB <= updB ? rd[headP1] : 5'd0;
        end
    end

    // Payload needs no reset: it is only observed through a valid entry
    always_ff @(posedge clk) begin
        if (doAllocA) begin
            wr[tail] <= alloc_wr_A;
            rd[tail] <= alloc_rd_A;
        end
        if (doAllocB) begin
            wr[alloc_tag_B] <= alloc_wr_B;
            rd[alloc_tag_B] <= alloc_rd_B;
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-order entries (power of two, equal to RRF size).
REQ-002 SHALL have parameter TAGW, default 3, width of entry index, log2(DEPTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all entries.
REQ-006 alloc_en_A / alloc_en_B  input  1 each  dispatch request for decoded instruction A (older) / B.
REQ-007 alloc_wr_A / alloc_wr_B  input  1 each  instruction writes a GPR.
REQ-008 alloc_rd_A / alloc_rd_B  input  5 each  destination GPR address.
REQ-009 alloc_ready  output  1  high when at least 2 entries are free.
REQ-010 alloc_tag_A / alloc_tag_B  output  TAGW each  entry index assigned to A / B this cycle.
REQ-011 fin_en_A / fin_en_B  input  1 each  execution-finished strobe.
REQ-012 fin_tag_A / fin_tag_B  input  TAGW each  entry index of finished instruction.
REQ-013 updateEnA / updateEnB  output  1 each  registered ARF-update strobe to register file.
REQ-014 updateAddrA / updateAddrB  output  5 each  registered GPR address to update.
REQ-015 count  output  TAGW+1  number of valid entries.

Function
REQ-016 SHALL hold per entry: valid, done, wr, rd[4:0]; head and tail pointers TAGW bits, wrapping modulo DEPTH.
REQ-017 alloc_ready SHALL be combinational: count <= DEPTH-2.
REQ-018 alloc_tag_A SHALL equal tail; alloc_tag_B SHALL equal tail+1 if alloc_en_A is high, else tail (combinational).
REQ-019 Allocation SHALL occur only when alloc_ready is high; alloc requests while alloc_ready is low SHALL be ignored (no state change).
REQ-020 alloc_en_B without alloc_en_A SHALL allocate B alone at tail; both high SHALL allocate A at tail, B at tail+1, tail advancing by 2.
REQ-021 Allocated entry SHALL be written valid=1, done=0, wr/rd captured, at the clock edge.
REQ-022 fin_en_X SHALL set done of entry fin_tag_X at the clock edge; finish to an invalid entry SHALL be ignored; both ports naming the same tag SHALL be harmless.
REQ-023 Retire SHALL be in order: head retires if valid&done; head+1 retires in the same cycle only if head retires and head+1 is valid&done; maximum 2 per cycle.
REQ-024 A done bit set at edge k SHALL make the entry retirable no earlier than edge k+1 (no same-cycle finish bypass).
REQ-025 At a retiring edge, retired entries SHALL clear valid, head SHALL advance by the number retired.
REQ-026 First retired entry SHALL drive updateEnA<=wr, updateAddrA<=rd; second SHALL drive updateEnB/updateAddrB likewise; the outputs are registered, visible the cycle after the retiring edge.
REQ-027 updateEnA/B SHALL be 0 in any cycle following an edge with no corresponding retirement; entries with wr=0 retire silently (updateEn 0).
REQ-028 updateAddrX SHALL be 0 whenever updateEnX is 0.
REQ-029 count SHALL update as count + allocated - retired in one edge; simultaneous allocate and retire SHALL both occur.
REQ-030 Full (count=DEPTH): alloc_ready 0, retire continues; empty (count=0): no retire, updateEn 0.
REQ-031 flush SHALL take priority over alloc, finish and retire: all valid cleared, head=tail=count=0, update outputs 0 next cycle.

Reset
REQ-032 rst_n low SHALL immediately clear all entry valid/done, head, tail, count, updateEnA/B, updateAddrA/B to 0; alloc_ready SHALL then read 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight entries with no update strobe issued.

Verification
REQ-034 Reset, then alloc A(rd=5,wr=1) and B(rd=9,wr=1) -> tags 0,1; count=2; no update strobes.
REQ-035 Finish tag 1 then tag 0 on later cycle -> nothing retires until tag 0 done; next edge both retire; following cycle updateEnA=1 addr 5, updateEnB=1 addr 9; count=0.
REQ-036 Fill 8 entries -> count=8, alloc_ready=0; further alloc ignored; tail wraps to 0 after retiring and reallocating (tags 7 then 0).
REQ-037 Head entry wr=0 done with head+1 wr=1 rd=3 done -> both retire; updateEnA=0, updateEnB=1 addr 3.
REQ-038 Same cycle: alloc 2, retire 2 at count=6 -> count stays 6, alloc_ready stays 1.
REQ-039 flush (or rst_n low) with 4 valid entries, 2 done -> count=0, no update strobes, next alloc receives tag 0.
